// File: rtl/perceptron.sv
// rtl/perceptron.sv - single Q16.16 perceptron unit with in-place gradient-descent weight update
// Optional feature macro: PERCEPTRON_BIAS_EN (adds a trainable bias register; otherwise bias is 0).
// Forward path, derivative and local gradient are purely combinational; only the
// weight (and optional bias) registers are clocked.

module perceptron #(
  parameter int input_units  = 2,
  parameter int output_units = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [input_units-1:0][31:0]     values,
  input  logic [1:0]                       activation,
  input  logic                             training,
  input  logic [31:0]                      learning_rate,
  input  logic [output_units-1:0][31:0]    next_layer_weights,
  input  logic [output_units-1:0][31:0]    error_gradient_next_layer,
  output logic [31:0]                      prediction,
  output logic [31:0]                      error_gradient,
  output logic [input_units-1:0][31:0]     current_weights
);

  localparam logic [31:0] ONE  = 32'h0001_0000;
  localparam logic [31:0] HALF = 32'h0000_8000;

  localparam logic [1:0] ACT_LINEAR  = 2'd0;
  localparam logic [1:0] ACT_RELU    = 2'd1;
  localparam logic [1:0] ACT_SIGMOID = 2'd2;

  // Sign-extend a 32-bit sfp word into the wide accumulator domain.
  function automatic logic signed [47:0] sx48(input logic [31:0] x);
    return {{16{x[31]}}, x};
  endfunction

  // Clamp a wide accumulator back to the 32-bit sfp range.
  function automatic logic [31:0] sat48(input logic signed [47:0] x);
    if (x[47:31] == {17{x[47]}}) begin
      return x[31:0];
    end else if (x[47]) begin
      return 32'h8000_0000;
    end else begin
      return 32'h7FFF_FFFF;
    end
  endfunction

  // Q16.16 multiply: exact 64-bit product, floor shift by 16, then saturate.
  function automatic logic [31:0] mul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ae;
    logic signed [63:0] be;
    logic signed [63:0] p;
    logic signed [63:0] s;
    ae = {{32{a[31]}}, a};
    be = {{32{b[31]}}, b};
    p  = ae * be;
    s  = p >>> 16;
    if (s[63:31] == {33{s[63]}}) begin
      return s[31:0];
    end else if (s[63]) begin
      return 32'h8000_0000;
    end else begin
      return 32'h7FFF_FFFF;
    end
  endfunction

  logic [input_units-1:0][31:0] w_q;
  logic [input_units-1:0][31:0] w_d;
  logic [31:0]                  bias;

  logic signed [47:0] z_acc;
  logic [31:0]        z;
  logic signed [47:0] sig_acc;
  logic [31:0]        act_a;
  logic [31:0]        fprime;
  logic signed [47:0] g_acc;
  logic [31:0]        g_sum;
  logic [31:0]        grad;
  logic [31:0]        step;

`ifdef PERCEPTRON_BIAS_EN
  logic [31:0] bias_q;
  logic [31:0] bias_d;

  assign bias = bias_q;
`else
  assign bias = 32'h0000_0000;
`endif

  // Forward pass: weighted sum, activation and its derivative.
  always_comb begin
    z_acc = sx48(bias);
    for (int i = 0; i < input_units; i++) begin
      z_acc = z_acc + sx48(mul(w_q[i], values[i]));
    end
    z = sat48(z_acc);

    // Hard-sigmoid: HALF + z/4 computed wide so large |z| cannot wrap before the clamp.
    sig_acc = sx48(HALF) + (sx48(z) >>> 2);

    act_a  = z;
    fprime = ONE;
    case (activation)
      ACT_RELU: begin
        act_a  = z[31] ? 32'h0000_0000 : z;
        fprime = (!z[31] && (z != 32'h0000_0000)) ? ONE : 32'h0000_0000;
      end
      ACT_SIGMOID: begin
        if (sig_acc[47]) begin
          act_a = 32'h0000_0000;
        end else if (sig_acc > sx48(ONE)) begin
          act_a = ONE;
        end else begin
          act_a = sig_acc[31:0];
        end
        fprime = mul(act_a, ONE - act_a);
      end
      default: begin
        act_a  = z;
        fprime = ONE;
      end
    endcase
  end

  // Backward pass: downstream gradient sum scaled by the local derivative.
  always_comb begin
    g_acc = '0;
    for (int k = 0; k < output_units; k++) begin
      g_acc = g_acc + sx48(mul(next_layer_weights[k], error_gradient_next_layer[k]));
    end
    g_sum = sat48(g_acc);
    grad  = mul(fprime, g_sum);
  end

  // Candidate next weights; the shared step lr*grad is applied to every input.
  always_comb begin
    step = mul(learning_rate, grad);
    w_d  = w_q;
    for (int i = 0; i < input_units; i++) begin
      w_d[i] = sat48(sx48(w_q[i]) - sx48(mul(step, values[i])));
    end
  end

  // Weight registers: asynchronous reset to a small ramp, update only while training.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < input_units; i++) begin
        w_q[i] <= 32'((i + 1) * 32'h0000_1000);
      end
    end else if (training) begin
      w_q <= w_d;
    end
  end

`ifdef PERCEPTRON_BIAS_EN
  // Bias follows the same step as a weight whose input is always ONE.
  always_comb begin
    bias_d = sat48(sx48(bias_q) - sx48(step));
  end

  // Bias register: cleared by reset, updated alongside the weights.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bias_q <= 32'h0000_0000;
    end else if (training) begin
      bias_q <= bias_d;
    end
  end
`endif

  assign prediction      = act_a;
  assign error_gradient  = grad;
  assign current_weights = w_q;

endmodule

// File: tb/tb_perceptron.sv
// tb/tb_perceptron.sv - directed self-checking bench for perceptron

module tb_perceptron;

  localparam logic [31:0] ONE  = 32'h0001_0000;
  localparam logic [31:0] MONE = 32'hFFFF_0000;

  logic              clk;
  logic              rst;
  logic [1:0][31:0]  values;
  logic [1:0]        activation;
  logic              training;
  logic [31:0]       learning_rate;
  logic [0:0][31:0]  next_layer_weights;
  logic [0:0][31:0]  error_gradient_next_layer;
  logic [31:0]       prediction;
  logic [31:0]       error_gradient;
  logic [1:0][31:0]  current_weights;

  int pass_cnt;
  int total_cnt;

  perceptron #(.input_units(2), .output_units(1)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .values                    (values),
    .activation                (activation),
    .training                  (training),
    .learning_rate             (learning_rate),
    .next_layer_weights        (next_layer_weights),
    .error_gradient_next_layer (error_gradient_next_layer),
    .prediction                (prediction),
    .error_gradient            (error_gradient),
    .current_weights           (current_weights)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_vals(input logic [31:0] v0, input logic [31:0] v1);
    values[0] = v0;
    values[1] = v1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    set_vals(32'h0, 32'h0);
    activation = 2'd2;
    training = 1'b1;
    learning_rate = ONE;
    next_layer_weights[0] = ONE;
    error_gradient_next_layer[0] = ONE;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (current_weights[0] !== 32'h0000_1000) $display("FAIL reset_w0 got %h want %h", current_weights[0], 32'h0000_1000);
    else pass_cnt++;
    total_cnt++;
    if (current_weights[1] !== 32'h0000_2000) $display("FAIL reset_w1 got %h want %h", current_weights[1], 32'h0000_2000);
    else pass_cnt++;
    total_cnt++;
    if (prediction !== 32'h0000_8000) $display("FAIL reset_pred got %h want %h", prediction, 32'h0000_8000);
    else pass_cnt++;
    total_cnt++;
    if (error_gradient !== 32'h0000_4000) $display("FAIL reset_grad got %h want %h", error_gradient, 32'h0000_4000);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (current_weights !== {32'h0000_2000, 32'h0000_1000}) $display("FAIL reset_held got %h want %h", current_weights, {32'h0000_2000, 32'h0000_1000});
    else pass_cnt++;
    training = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_hold();
    @(negedge clk);
    activation = 2'd0;
    training = 1'b0;
    set_vals(ONE, ONE);
    #1;
    total_cnt++;
    if (prediction !== 32'h0000_3000) $display("FAIL hold_pred_pre got %h want %h", prediction, 32'h0000_3000);
    else pass_cnt++;
    total_cnt++;
    if (error_gradient !== ONE) $display("FAIL hold_grad got %h want %h", error_gradient, ONE);
    else pass_cnt++;
    repeat (10) @(posedge clk);
    #1;
    total_cnt++;
    if (current_weights !== {32'h0000_2000, 32'h0000_1000}) $display("FAIL hold_weights got %h want %h", current_weights, {32'h0000_2000, 32'h0000_1000});
    else pass_cnt++;
    total_cnt++;
    if (prediction !== 32'h0000_3000) $display("FAIL hold_pred_post got %h want %h", prediction, 32'h0000_3000);
    else pass_cnt++;
  endtask

  task automatic test_activations();
    @(negedge clk);
    training = 1'b0;
    activation = 2'd1;
    set_vals(ONE, ONE);
    #1;
    total_cnt++;
    if (prediction !== 32'h0000_3000) $display("FAIL relu_pos got %h want %h", prediction, 32'h0000_3000);
    else pass_cnt++;
    activation = 2'd3;
    set_vals(MONE, 32'h0);
    #1;
    total_cnt++;
    if (prediction !== 32'hFFFF_F000) $display("FAIL act3_linear got %h want %h", prediction, 32'hFFFF_F000);
    else pass_cnt++;
    activation = 2'd0;
    set_vals(32'hFFFF_FFFF, 32'h0);
    #1;
    total_cnt++;
    if (prediction !== 32'hFFFF_FFFF) $display("FAIL mul_floor got %h want %h", prediction, 32'hFFFF_FFFF);
    else pass_cnt++;
    activation = 2'd2;
    set_vals(ONE, ONE);
    #1;
    total_cnt++;
    if (prediction !== 32'h0000_8C00) $display("FAIL sig_mid got %h want %h", prediction, 32'h0000_8C00);
    else pass_cnt++;
    total_cnt++;
    if (error_gradient !== 32'h0000_3F70) $display("FAIL sig_grad got %h want %h", error_gradient, 32'h0000_3F70);
    else pass_cnt++;
    set_vals(32'h7FFF_0000, 32'h7FFF_0000);
    #1;
    total_cnt++;
    if (prediction !== ONE) $display("FAIL sig_hi got %h want %h", prediction, ONE);
    else pass_cnt++;
    set_vals(32'h8000_0000, 32'h8000_0000);
    #1;
    total_cnt++;
    if (prediction !== 32'h0) $display("FAIL sig_lo got %h want %h", prediction, 32'h0);
    else pass_cnt++;
    activation = 2'd0;
    set_vals(ONE, ONE);
    next_layer_weights[0] = 32'h0002_0000;
    error_gradient_next_layer[0] = 32'hFFFF_8000;
    #1;
    total_cnt++;
    if (error_gradient !== MONE) $display("FAIL grad_sum got %h want %h", error_gradient, MONE);
    else pass_cnt++;
    next_layer_weights[0] = ONE;
    error_gradient_next_layer[0] = ONE;
  endtask

  task automatic test_train();
    logic [31:0] exp_pred;
`ifdef PERCEPTRON_BIAS_EN
    exp_pred = 32'hFFFD_3000;
`else
    exp_pred = 32'hFFFE_3000;
`endif
    @(negedge clk);
    activation = 2'd0;
    set_vals(ONE, ONE);
    learning_rate = ONE;
    next_layer_weights[0] = ONE;
    error_gradient_next_layer[0] = ONE;
    training = 1'b1;
    #1;
    total_cnt++;
    if (error_gradient !== ONE) $display("FAIL train_grad got %h want %h", error_gradient, ONE);
    else pass_cnt++;
    @(posedge clk);
    #1;
    training = 1'b0;
    total_cnt++;
    if (current_weights !== {32'hFFFF_2000, 32'hFFFF_1000}) $display("FAIL train_weights got %h want %h", current_weights, {32'hFFFF_2000, 32'hFFFF_1000});
    else pass_cnt++;
    total_cnt++;
    if (prediction !== exp_pred) $display("FAIL train_pred got %h want %h", prediction, exp_pred);
    else pass_cnt++;
  endtask

  task automatic test_relu_no_update();
    pulse_reset();
    activation = 2'd1;
    set_vals(MONE, 32'h0);
    training = 1'b1;
    #1;
    total_cnt++;
    if (prediction !== 32'h0) $display("FAIL relu_neg_pred got %h want %h", prediction, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (error_gradient !== 32'h0) $display("FAIL relu_neg_grad got %h want %h", error_gradient, 32'h0);
    else pass_cnt++;
    @(posedge clk);
    #1;
    training = 1'b0;
    total_cnt++;
    if (current_weights !== {32'h0000_2000, 32'h0000_1000}) $display("FAIL relu_no_update got %h want %h", current_weights, {32'h0000_2000, 32'h0000_1000});
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    pulse_reset();
    activation = 2'd0;
    set_vals(ONE, ONE);
    learning_rate = ONE;
    next_layer_weights[0] = ONE;
    error_gradient_next_layer[0] = MONE;
    training = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    training = 1'b0;
    total_cnt++;
    if (current_weights !== {32'h0002_2000, 32'h0002_1000}) $display("FAIL sat_grow got %h want %h", current_weights, {32'h0002_2000, 32'h0002_1000});
    else pass_cnt++;
    set_vals(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    #1;
    total_cnt++;
    if (prediction !== 32'h7FFF_FFFF) $display("FAIL sat_pos got %h want %h", prediction, 32'h7FFF_FFFF);
    else pass_cnt++;
    set_vals(32'h8000_0000, 32'h8000_0000);
    #1;
    total_cnt++;
    if (prediction !== 32'h8000_0000) $display("FAIL sat_neg got %h want %h", prediction, 32'h8000_0000);
    else pass_cnt++;
    error_gradient_next_layer[0] = ONE;
  endtask

  task automatic test_reset_mid_training();
    pulse_reset();
    activation = 2'd0;
    set_vals(ONE, ONE);
    learning_rate = ONE;
    next_layer_weights[0] = ONE;
    error_gradient_next_layer[0] = ONE;
    training = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if (current_weights !== {32'hFFFF_2000, 32'hFFFF_1000}) $display("FAIL mid_first_step got %h want %h", current_weights, {32'hFFFF_2000, 32'hFFFF_1000});
    else pass_cnt++;
    #1;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (current_weights !== {32'h0000_2000, 32'h0000_1000}) $display("FAIL mid_async_reset got %h want %h", current_weights, {32'h0000_2000, 32'h0000_1000});
    else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if (current_weights !== {32'h0000_2000, 32'h0000_1000}) $display("FAIL mid_reset_hold got %h want %h", current_weights, {32'h0000_2000, 32'h0000_1000});
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    training = 1'b0;
    total_cnt++;
    if (current_weights !== {32'hFFFF_2000, 32'hFFFF_1000}) $display("FAIL mid_resume got %h want %h", current_weights, {32'hFFFF_2000, 32'hFFFF_1000});
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_hold();
    test_activations();
    test_train();
    test_relu_no_update();
    test_saturation();
    test_reset_mid_training();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
